pc_sequencer: RTL
=================

# pc_sequencer

Multi-cycle sequencer for the program counter of the 10-bit MCU fetch path. It steps the core through FETCH/EXEC/INTR states and decides when the PC register updates and with which value. Next-PC sources are PC+1, branch target, jump target, interrupt vector, and saved return address. The block sits between the control/branch-decision logic and the PC register, and replaces free-running PC increment with explicit per-instruction write enables.

## Interface
- WIDTH, 10: PC and all address widths.
- clk  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- PC_CUR  in  WIDTH  current PC register value.
- STALL  in  1  instruction memory not ready; holds FETCH.
- BR_TAKEN  in  1  conditional branch resolved taken (valid in EXEC).
- BR_TARGET  in  WIDTH  branch target.
- JUMP  in  1  unconditional jump (valid in EXEC).
- JUMP_TARGET  in  WIDTH  jump target.
- MRET  in  1  return-from-interrupt instruction (valid in EXEC).
- INTR  in  1  external interrupt request, level, synchronous to clk.
- INT_EN  in  1  global interrupt enable.
- MTVEC  in  WIDTH  interrupt vector address.
- PC_WE  out  1  PC register load enable.
- PC_NEXT  out  WIDTH  value loaded into PC when PC_WE=1.
- IR_LD  out  1  instruction register load strobe.
- INT_TAKEN  out  1  one-cycle pulse, interrupt entry.
- MEPC  out  WIDTH  saved return address.
- STATE  out  2  encoded state: FETCH=0, EXEC=1, INTR=2.

## Operation
- FETCH: IR_LD=1 when STALL=0, then the block moves to EXEC. When STALL=1, IR_LD=0 and the block stays in FETCH. PC_WE=0.
- EXEC: PC_WE=1. PC_NEXT is chosen by fixed priority:
  - MRET → MEPC
  - else JUMP → JUMP_TARGET
  - else BR_TAKEN → BR_TARGET
  - else PC_CUR+1, modulo 2^WIDTH, so 1023 wraps to 0.
- EXEC exit: if pending=1 and INT_EN=1 and MRET=0, the next state is INTR. In that case the EXEC PC_NEXT value is latched into an internal return register. Otherwise the next state is FETCH.
- INTR: PC_WE=1, PC_NEXT=MTVEC, INT_TAKEN=1. MEPC is loaded from the return register, pending is cleared, and the next state is FETCH.
- pending flag: set on any cycle with INTR=1. Cleared only on INTR entry. INTR=1 in the same cycle as entry keeps pending set (set wins over clear).
- While INT_EN=0, pending is retained but not serviced.
- Simultaneous MRET and pending interrupt: the MRET completes first. The interrupt is taken at the next eligible EXEC.
- Unused encoding 3: recovers to FETCH with all strobes 0.
- All outputs not listed for a state are 0. PC_NEXT is 0 when PC_WE=0.

## Timing
- Reset (RST_N=0, async): STATE=FETCH; PC_WE, IR_LD, INT_TAKEN, PC_NEXT, MEPC=0; pending=0; return register=0.
- PC_WE, PC_NEXT, IR_LD, INT_TAKEN: combinational from state and inputs. PC_WE and PC_NEXT are valid during the EXEC/INTR cycle, and the PC register updates at that cycle's edge.
- STATE, MEPC, pending: registered.
- Minimum instruction time: 2 cycles (FETCH+EXEC). Each STALL cycle adds 1. An interrupt adds 1 cycle (INTR).
- INTR latency: an INTR pulse seen by the end of EXEC is serviced in the immediately following cycle.
- RST_N assertion mid-instruction: abandons the state immediately, with no PC_WE pulse. Release is sampled at the next rising edge, and operation restarts in FETCH.

## Configuration
- PCSEQ_INTR_EN defined:
  - full interrupt logic as above.
- PCSEQ_INTR_EN undefined:
  - INTR, INT_EN and MTVEC are ignored; INTR state is unreachable.
  - INT_TAKEN=0 and MEPC=0 permanently.
  - MRET is treated as no-op priority (falls through to JUMP/BR/PC+1).

## Test plan
- Sequential run: PC_CUR=5, STALL=0, no controls → IR_LD in FETCH, then EXEC with PC_WE=1, PC_NEXT=6. Repeats every 2 cycles.
- Priority and wrap:
  - JUMP=1, JUMP_TARGET=0x200 with BR_TAKEN=1, BR_TARGET=0x010 → PC_NEXT=0x200.
  - PC_CUR=1023 with no controls → PC_NEXT=0.
- Stall: STALL=1 for 3 cycles in FETCH → STATE stays 0, IR_LD=0, PC_WE=0. EXEC follows 1 cycle after STALL drops.
- Interrupt entry and return:
  - INT_EN=1, INTR pulse during FETCH with PC_CUR=0x040, MTVEC=0x300 → EXEC PC_NEXT=0x041, then INTR with PC_NEXT=0x300, INT_TAKEN=1, MEPC=0x041 afterwards.
  - A later MRET → PC_NEXT=0x041.
- Masking: INTR pulse with INT_EN=0 → no INTR state. Raising INT_EN 4 instructions later → INTR taken after the next EXEC.
- Async reset mid-EXEC: RST_N low between edges → STATE=0, PC_WE=0 immediately, MEPC=0, pending cleared.

Source files
------------

// File: rtl/pc_sequencer.sv
// PC sequencer: FETCH/EXEC/INTR stepping with explicit PC write enables and next-PC selection.
// Optional interrupt support is compiled in with the PCSEQ_INTR_EN macro.
module pc_sequencer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc_cur,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             mret,
  input  logic             intr,
  input  logic             int_en,
  input  logic [WIDTH-1:0] mtvec,
  output logic             pc_we,
  output logic [WIDTH-1:0] pc_next,
  output logic             ir_ld,
  output logic             int_taken,
  output logic [WIDTH-1:0] mepc,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_INTR  = 2'd2,
    S_BAD   = 2'd3
  } state_t;

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] exec_target;
  logic             take_int;
  logic             mret_eff;

`ifdef PCSEQ_INTR_EN
  logic             pending_q;
  logic [WIDTH-1:0] ret_q;
  logic [WIDTH-1:0] mepc_q;

  // A request arriving during EXEC itself is still serviced right after that EXEC.
  assign mret_eff = mret;
  assign take_int = (state_q == S_EXEC) && (pending_q || intr) && int_en && !mret;
  assign mepc     = mepc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      ret_q     <= '0;
      mepc_q    <= '0;
    end else begin
      if (intr) begin
        pending_q <= 1'b1;
      end else if (state_q == S_INTR) begin
        pending_q <= 1'b0;
      end
      if (take_int) begin
        ret_q <= exec_target;
      end
      if (state_q == S_INTR) begin
        mepc_q <= ret_q;
      end
    end
  end
`else
  logic unused_intr;
  assign unused_intr = ^{intr, int_en, mtvec, mret};
  assign mret_eff    = 1'b0;
  assign take_int    = 1'b0;
  assign mepc        = '0;
`endif

  always_comb begin
    if (mret_eff) begin
      exec_target = mepc;
    end else if (jump) begin
      exec_target = jump_target;
    end else if (br_taken) begin
      exec_target = br_target;
    end else begin
      exec_target = pc_cur + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Strobes are forced low while reset is held so an abandoned EXEC never writes the PC.
  always_comb begin
    state_nxt = S_FETCH;
    pc_we     = 1'b0;
    pc_next   = '0;
    ir_ld     = 1'b0;
    int_taken = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          if (stall) begin
            state_nxt = S_FETCH;
          end else begin
            ir_ld     = 1'b1;
            state_nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          pc_we     = 1'b1;
          pc_next   = exec_target;
          state_nxt = take_int ? S_INTR : S_FETCH;
        end
`ifdef PCSEQ_INTR_EN
        S_INTR: begin
          pc_we     = 1'b1;
          pc_next   = mtvec;
          int_taken = 1'b1;
          state_nxt = S_FETCH;
        end
`endif
        default: begin
          state_nxt = S_FETCH;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule
